// File: rtl/perceptron_trainer.sv
//------------------------------------------------------------------------------
// Module      : perceptron_trainer
// Description : Online perceptron trainer for a 10-class digit classifier;
//               sequential class scoring with saturating weight updates.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module perceptron_trainer #(
    parameter int N_FEAT  = 7,
    parameter int N_CLASS = 10,
    parameter int W_W     = 4,
    parameter int S_W     = W_W + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_FEAT-1:0]     in_feat,
    input  logic [3:0]            in_label,
    input  logic                  train_en,
    output logic                  out_valid,
    output logic [3:0]            out_class,
    output logic                  out_correct,
    input  logic [3:0]            rd_class,
    input  logic [2:0]            rd_feat,
    output logic signed [W_W-1:0] rd_weight
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCORE  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [3:0]            c_n_class    = 4'(N_CLASS);
    localparam logic [3:0]            c_last_class = 4'(N_CLASS - 1);
    localparam logic [2:0]            c_bias_sel   = 3'(N_FEAT);
    localparam logic signed [W_W-1:0] c_w_max      = {1'b0, {(W_W-1){1'b1}}};
    localparam logic signed [W_W-1:0] c_w_min      = {1'b1, {(W_W-1){1'b0}}};
    localparam logic signed [W_W-1:0] c_w_one      = W_W'(1);

    state_t                  state_q, state_d;
    logic [3:0]              cls_q, cls_d;
    logic [N_FEAT-1:0]       feat_q, feat_d;
    logic [3:0]              label_q, label_d;
    logic                    train_q, train_d;
    logic [3:0]              best_q, best_d;
    logic signed [S_W-1:0]   best_score_q, best_score_d;
    logic                    out_valid_q, out_valid_d;
    logic [3:0]              out_class_q, out_class_d;
    logic                    out_correct_q, out_correct_d;
    logic signed [W_W-1:0]   w_q [N_CLASS][N_FEAT];
    logic signed [W_W-1:0]   w_d [N_CLASS][N_FEAT];
    logic signed [W_W-1:0]   b_q [N_CLASS];
    logic signed [W_W-1:0]   b_d [N_CLASS];
    logic signed [S_W-1:0]   w_score;
    logic                    w_do_update;

    function automatic logic signed [S_W-1:0] sext(input logic signed [W_W-1:0] v);
        return {{(S_W-W_W){v[W_W-1]}}, v};
    endfunction

    // Step by one toward +/-; pinned at the signed extremes instead of wrapping.
    function automatic logic signed [W_W-1:0] sat_step(input logic signed [W_W-1:0] v,
                                                       input logic inc);
        if (inc) return (v == c_w_max) ? v : v + c_w_one;
        else     return (v == c_w_min) ? v : v - c_w_one;
    endfunction

    always_comb begin
        w_score = sext(b_q[cls_q]);
        for (int i = 0; i < N_FEAT; i++) begin
            if (feat_q[i]) w_score = w_score + sext(w_q[cls_q][i]);
        end
    end

    assign w_do_update = train_q && (label_q < c_n_class) && (best_q != label_q);

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        feat_d        = feat_q;
        label_d       = label_q;
        train_d       = train_q;
        best_d        = best_q;
        best_score_d  = best_score_q;
        out_valid_d   = 1'b0;
        out_class_d   = out_class_q;
        out_correct_d = out_correct_q;
        w_d           = w_q;
        b_d           = b_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    feat_d  = in_feat;
                    label_d = in_label;
                    train_d = train_en;
                    cls_d   = '0;
                    state_d = ST_SCORE;
                end
            end
            ST_SCORE: begin
                if ((cls_q == '0) || (w_score > best_score_q)) begin
                    best_d       = cls_q;
                    best_score_d = w_score;
                end
                if (cls_q == c_last_class) begin
                    state_d       = ST_UPDATE;
                    out_valid_d   = 1'b1;
                    out_class_d   = best_d;
                    out_correct_d = (best_d == label_q) && (label_q < c_n_class);
                end else begin
                    cls_d = cls_q + 4'd1;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                if (w_do_update) begin
                    for (int c = 0; c < N_CLASS; c++) begin
                        if (4'(c) == label_q) begin
                            b_d[c] = sat_step(b_q[c], 1'b1);
                            for (int i = 0; i < N_FEAT; i++) begin
                                if (feat_q[i]) w_d[c][i] = sat_step(w_q[c][i], 1'b1);
                            end
                        end else if (4'(c) == best_q) begin
                            b_d[c] = sat_step(b_q[c], 1'b0);
                            for (int i = 0; i < N_FEAT; i++) begin
                                if (feat_q[i]) w_d[c][i] = sat_step(w_q[c][i], 1'b0);
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cls_q         <= '0;
            feat_q        <= '0;
            label_q       <= '0;
            train_q       <= 1'b0;
            best_q        <= '0;
            best_score_q  <= '0;
            out_valid_q   <= 1'b0;
            out_class_q   <= '0;
            out_correct_q <= 1'b0;
            for (int c = 0; c < N_CLASS; c++) begin
                b_q[c] <= '0;
                for (int i = 0; i < N_FEAT; i++) w_q[c][i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            feat_q        <= feat_d;
            label_q       <= label_d;
            train_q       <= train_d;
            best_q        <= best_d;
            best_score_q  <= best_score_d;
            out_valid_q   <= out_valid_d;
            out_class_q   <= out_class_d;
            out_correct_q <= out_correct_d;
            w_q           <= w_d;
            b_q           <= b_d;
        end
    end

    // Readback taps the registered array, so a read in UPDATE sees the old value.
    always_comb begin
        rd_weight = '0;
        if (rd_class < c_n_class) begin
            if (rd_feat < c_bias_sel)       rd_weight = w_q[rd_class][rd_feat];
            else if (rd_feat == c_bias_sel) rd_weight = b_q[rd_class];
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign out_class   = out_class_q;
    assign out_correct = out_correct_q;

endmodule

`default_nettype wire

// File: tb/tb_perceptron_trainer.sv
//------------------------------------------------------------------------------
// Module      : tb_perceptron_trainer
// Description : Self-checking bench for perceptron_trainer against a score/argmax
//               reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_perceptron_trainer;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_feat;
    logic [3:0]        in_label;
    logic              train_en;
    logic              out_valid;
    logic [3:0]        out_class;
    logic              out_correct;
    logic [3:0]        rd_class;
    logic [2:0]        rd_feat;
    logic signed [3:0] rd_weight;

    int n_checks = 0;
    int n_fail   = 0;

    int mw [10][7];
    int mb [10];

    perceptron_trainer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_feat    (in_feat),
        .in_label   (in_label),
        .train_en   (train_en),
        .out_valid  (out_valid),
        .out_class  (out_class),
        .out_correct(out_correct),
        .rd_class   (rd_class),
        .rd_feat    (rd_feat),
        .rd_weight  (rd_weight)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic m_clear();
        for (int c = 0; c < 10; c++) begin
            mb[c] = 0;
            for (int i = 0; i < 7; i++) mw[c][i] = 0;
        end
    endtask

    function automatic int m_score(int c, logic [6:0] f);
        int s = mb[c];
        for (int i = 0; i < 7; i++) if (f[i]) s += mw[c][i];
        return s;
    endfunction

    function automatic logic [3:0] m_predict(logic [6:0] f);
        int best = 0;
        int bs = m_score(0, f);
        for (int c = 1; c < 10; c++) begin
            if (m_score(c, f) > bs) begin
                bs = m_score(c, f);
                best = c;
            end
        end
        return 4'(best);
    endfunction

    function automatic int clamp(int v);
        return (v > 7) ? 7 : ((v < -8) ? -8 : v);
    endfunction

    task automatic m_train(logic [6:0] f, int label, bit tr, int best);
        if (tr && label < 10 && best != label) begin
            mb[label] = clamp(mb[label] + 1);
            mb[best]  = clamp(mb[best] - 1);
            for (int i = 0; i < 7; i++) begin
                if (f[i]) begin
                    mw[label][i] = clamp(mw[label][i] + 1);
                    mw[best][i]  = clamp(mw[best][i] - 1);
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    // Presents one sample, returns accept-to-out_valid latency (-1 on timeout).
    task automatic run_sample(input logic [6:0] f, input logic [3:0] label, input bit tr,
                              output int lat, output logic [3:0] cls, output logic corr);
        int k;
        in_feat = f; in_label = label; train_en = tr; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 30) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1; k++;
        end
        lat  = out_valid ? k : -1;
        cls  = out_class;
        corr = out_correct;
        @(posedge clk); #1;
    endtask

    // Counts readback entries (including out-of-range selects) differing from the model.
    task automatic count_weight_mismatches(output int nbad);
        int exp;
        nbad = 0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 8; i++) begin
                rd_class = 4'(c); rd_feat = 3'(i);
                #1;
                if (c >= 10)     exp = 0;
                else if (i < 7)  exp = mw[c][i];
                else             exp = mb[c];
                if (int'(rd_weight) != exp) nbad++;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int nbad;
        rst = 1'b1; in_valid = 1'b0; in_feat = '0; in_label = '0; train_en = 1'b0;
        rd_class = '0; rd_feat = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        m_clear();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== 4'd0 || out_correct !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b class=%0d correct=%b, need 1 0 0 0",
                     in_ready, out_valid, out_class, out_correct);
        end
        count_weight_mismatches(nbad);
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL reset_weights: %0d entries nonzero, need 0", nbad);
        end
    endtask

    task automatic test_zero_sample();
        int lat; logic [3:0] cls; logic corr; int nbad;
        run_sample(7'h00, 4'd3, 1'b0, lat, cls, corr);
        n_checks++;
        if (lat !== 11) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d, need 11", lat);
        end
        n_checks++;
        if (cls !== 4'd0 || corr !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_result: got class=%0d correct=%b, need 0 0", cls, corr);
        end
        count_weight_mismatches(nbad);
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL zero_weights: %0d entries nonzero, need 0", nbad);
        end
    endtask

    task automatic test_single_train();
        int lat; logic [3:0] cls; logic corr; int nbad;
        run_sample(7'b0000001, 4'd3, 1'b1, lat, cls, corr);
        n_checks++;
        if (lat !== 11 || cls !== 4'd0 || corr !== 1'b0) begin
            n_fail++;
            $display("FAIL train_first: got lat=%0d class=%0d correct=%b, need 11 0 0", lat, cls, corr);
        end
        m_train(7'b0000001, 3, 1'b1, 0);
        rd_class = 4'd3; rd_feat = 3'd7; #1;
        n_checks++;
        if (rd_weight !== 4'sd1) begin
            n_fail++;
            $display("FAIL train_b3: got %0d, need 1", rd_weight);
        end
        rd_class = 4'd0; rd_feat = 3'd0; #1;
        n_checks++;
        if (rd_weight !== -4'sd1) begin
            n_fail++;
            $display("FAIL train_w00: got %0d, need -1", rd_weight);
        end
        @(posedge clk); #1;
        count_weight_mismatches(nbad);
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL train_weights: %0d entries differ from model, need 0", nbad);
        end
        run_sample(7'b0000001, 4'd3, 1'b0, lat, cls, corr);
        n_checks++;
        if (cls !== 4'd3 || corr !== 1'b1) begin
            n_fail++;
            $display("FAIL replay: got class=%0d correct=%b, need 3 1", cls, corr);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_class !== 4'd3 || out_correct !== 1'b1) begin
            n_fail++;
            $display("FAIL hold: got valid=%b class=%0d correct=%b, need 0 3 1",
                     out_valid, out_class, out_correct);
        end
    endtask

    task automatic test_alternate();
        int lat; logic [3:0] cls; logic corr; int nbad; logic [3:0] exp; logic [3:0] lbl;
        for (int k = 0; k < 40; k++) begin
            lbl = (k % 2 == 0) ? 4'd1 : 4'd2;
            exp = m_predict(7'h7F);
            run_sample(7'h7F, lbl, 1'b1, lat, cls, corr);
            n_checks++;
            if (lat !== 11 || cls !== exp || corr !== (exp == lbl)) begin
                n_fail++;
                $display("FAIL alternate[%0d]: got lat=%0d class=%0d correct=%b, need 11 %0d %b",
                         k, lat, cls, corr, exp, exp == lbl);
            end
            m_train(7'h7F, int'(lbl), 1'b1, int'(exp));
        end
        count_weight_mismatches(nbad);
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL alternate_weights: %0d entries differ from model, need 0", nbad);
        end
    endtask

    task automatic test_random();
        int lat; logic [3:0] cls; logic corr; int nbad; logic [3:0] exp;
        logic [6:0] f; logic [3:0] lbl; bit tr; logic exp_corr;
        for (int k = 0; k < 30; k++) begin
            f   = 7'($urandom);
            lbl = 4'($urandom_range(0, 11));
            tr  = 1'($urandom_range(0, 1));
            exp = m_predict(f);
            exp_corr = (lbl < 10) && (exp == lbl);
            run_sample(f, lbl, tr, lat, cls, corr);
            n_checks++;
            if (lat !== 11 || cls !== exp || corr !== exp_corr) begin
                n_fail++;
                $display("FAIL random[%0d]: got lat=%0d class=%0d correct=%b, need 11 %0d %b",
                         k, lat, cls, corr, exp, exp_corr);
            end
            m_train(f, int'(lbl), tr, int'(exp));
        end
        count_weight_mismatches(nbad);
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL random_weights: %0d entries differ from model, need 0", nbad);
        end
    endtask

    task automatic test_bad_label();
        int lat; logic [3:0] cls; logic corr; int nbad; logic [3:0] exp;
        exp = m_predict(7'h55);
        run_sample(7'h55, 4'd12, 1'b1, lat, cls, corr);
        n_checks++;
        if (lat !== 11 || cls !== exp || corr !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_label: got lat=%0d class=%0d correct=%b, need 11 %0d 0", lat, cls, corr, exp);
        end
        count_weight_mismatches(nbad);
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL bad_label_weights: %0d entries changed, need 0", nbad);
        end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int pulses = 0;
        int bad_cls = 0;
        logic [3:0] exp;
        exp = m_predict(7'h03);
        in_feat = 7'h03; in_label = 4'd0; train_en = 1'b0; in_valid = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            if (out_valid) begin
                pulses++;
                if (out_class !== exp) bad_cls++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc.size() !== 5) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d accepts, need 5", acc.size());
        end
        for (int j = 1; j < acc.size(); j++) begin
            n_checks++;
            if (acc[j] - acc[j-1] !== 12) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles, need 12", j, acc[j] - acc[j-1]);
            end
        end
        n_checks++;
        if (pulses !== 4 || bad_cls !== 0) begin
            n_fail++;
            $display("FAIL b2b_results: got %0d pulses %0d wrong, need 4 pulses 0 wrong", pulses, bad_cls);
        end
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int k = 0; int seen = 0; int nbad;
        in_feat = 7'h7F; in_label = 4'd5; train_en = 1'b1; in_valid = 1'b1;
        while (!in_ready && k < 30) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready: got %b, need 1", in_ready);
        end
        repeat (15) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_pulse: got %0d out_valid cycles, need 0", seen);
        end
        count_weight_mismatches(nbad);
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_weights: %0d entries nonzero, need 0", nbad);
        end
    endtask

    initial begin
        test_reset();
        test_zero_sample();
        test_single_train();
        test_alternate();
        test_random();
        test_bad_label();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
